// File: rtl/pixel_pkg.sv
// Shared types and constants for the sprite pixel stream and the
// framebuffer write port.
package pixel_pkg;

  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned SCREEN_H  = 240;
  localparam int unsigned X_W       = 9;
  localparam int unsigned Y_W       = 8;
  localparam int unsigned COLOUR_W  = 3;
  localparam int unsigned FB_ADDR_W = 17;

  // One pixel as it travels through the input FIFO (21 bits).
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                last;
  } pixel_t;

  localparam int unsigned PIXEL_W = $bits(pixel_t);

  // Fate of a pixel once it reaches the output stage.
  typedef enum logic [1:0] {
    PIX_WRITE       = 2'd0,
    PIX_CLIPPED     = 2'd1,
    PIX_TRANSPARENT = 2'd2
  } pix_class_t;

  // Linear framebuffer address y*320 + x, built from shifts so no
  // multiplier is needed: 320 = 256 + 64.
  function automatic logic [FB_ADDR_W-1:0] fb_address(
    input logic [Y_W-1:0] y,
    input logic [X_W-1:0] x
  );
    logic [FB_ADDR_W-1:0] y_ext;
    y_ext = FB_ADDR_W'(y);
    return (y_ext << 8) + (y_ext << 6) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_plot_sink_if.sv
// Pixel stream in from the sprite drawer plus the framebuffer write port.
// master = environment (drawer feeding pixels, memory taking writes),
// slave  = pixel_plot_sink.
interface pixel_plot_sink_if;
  import pixel_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [X_W-1:0]       in_x;
  logic [Y_W-1:0]       in_y;
  logic [COLOUR_W-1:0]  in_colour;
  logic                 in_last;

  logic [FB_ADDR_W-1:0] fb_addr;
  logic [COLOUR_W-1:0]  fb_data;
  logic                 fb_wren;

  modport master (
    output in_valid, in_x, in_y, in_colour, in_last,
    input  in_ready, fb_addr, fb_data, fb_wren
  );

  modport slave (
    input  in_valid, in_x, in_y, in_colour, in_last,
    output in_ready, fb_addr, fb_data, fb_wren
  );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding incoming pixels until the output stage
// takes them. Head entry is visible combinationally on pop_data.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock_all,
  input  logic             reset_all,
  input  logic             push,
  input  pixel_t           push_data,
  input  logic             pop,
  output pixel_t           pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  pixel_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write.
  // NOTE: the entry array is deliberately left out of reset; the count and
  // pointers decide which entries are meaningful, and a reset-free array
  // maps onto plain RAM/flops without a reset fan-out.
  always_ff @(posedge clock_all) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_plot_sink.sv
// Receiving end of the sprite pixel stream: buffers pixels, clips them to
// the screen, drops the transparent key colour and issues one framebuffer
// write per surviving pixel. Reports end-of-sprite upstream.
module pixel_plot_sink
  import pixel_pkg::*;
#(
  parameter int unsigned         SCREEN_W      = pixel_pkg::SCREEN_W,
  parameter int unsigned         SCREEN_H      = pixel_pkg::SCREEN_H,
  parameter int unsigned         FIFO_DEPTH    = 4,
  parameter bit                  TRANSP_EN     = 1'b1,
  parameter logic [COLOUR_W-1:0] TRANSP_COLOUR = 3'b000
) (
  input  logic                 clock_all,
  input  logic                 reset_all,
  pixel_plot_sink_if.slave     bus,
  output logic                 sprite_done,
  output logic                 busy,
  output logic [FB_ADDR_W-1:0] plotted_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  pixel_t               in_pixel;
  pixel_t               head;
  logic                 push;
  logic                 pop;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Low while reset is applied and for the edge that samples it, so
  // in_ready only rises the cycle after reset deasserts.
  logic                 ready_en;
  pix_class_t           head_class;
  logic                 stage_valid;
  logic                 fb_wren_q;
  logic [FB_ADDR_W-1:0] fb_addr_q;
  logic [COLOUR_W-1:0]  fb_data_q;

  assign in_pixel = '{x:      bus.in_x,
                      y:      bus.in_y,
                      colour: bus.in_colour,
                      last:   bus.in_last};

  // Ready depends only on registered state, never on in_valid.
  assign bus.in_ready = ready_en && !fifo_full;
  assign push         = bus.in_valid && bus.in_ready;
  // The output stage never stalls, so any buffered pixel moves on at once.
  assign pop          = !fifo_empty;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_all (clock_all),
    .reset_all (reset_all),
    .push      (push),
    .push_data (in_pixel),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Classify the head entry: off-screen first, then transparent key.
  // NOTE: head_class gets a default before any branch so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    head_class = PIX_WRITE;
    if ((32'(head.x) >= SCREEN_W) || (32'(head.y) >= SCREEN_H)) begin
      head_class = PIX_CLIPPED;
    end else if (TRANSP_EN && (head.colour == TRANSP_COLOUR)) begin
      head_class = PIX_TRANSPARENT;
    end
  end

  // Output stage: register the popped pixel's write strobe, address, data
  // and end-of-sprite pulse; address/data hold when nothing is written.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      ready_en    <= 1'b0;
      stage_valid <= 1'b0;
      sprite_done <= 1'b0;
      fb_wren_q   <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
    end else begin
      ready_en    <= 1'b1;
      stage_valid <= pop;
      sprite_done <= pop && head.last;
      fb_wren_q   <= pop && (head_class == PIX_WRITE);
      if (pop && (head_class == PIX_WRITE)) begin
        fb_addr_q <= fb_address(head.y, head.x);
        fb_data_q <= head.colour;
      end
    end
  end

  // Count written pixels on the edge that ends each write cycle; saturate.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      plotted_count <= '0;
    end else if (fb_wren_q && (plotted_count != '1)) begin
      plotted_count <= plotted_count + 1'b1;
    end
  end

  assign bus.fb_wren = fb_wren_q;
  assign bus.fb_addr = fb_addr_q;
  assign bus.fb_data = fb_data_q;
  assign busy        = (fifo_count != '0) || stage_valid;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: reset, single pixel, long burst,
// clipping, transparency, streaming through reset release, reset mid-sprite.
module tb_pixel_plot_sink;
  import pixel_pkg::*;

  logic                 clock_all;
  logic                 reset_all;
  logic                 sprite_done;
  logic                 busy;
  logic [FB_ADDR_W-1:0] plotted_count;

  pixel_plot_sink_if bus ();

  pixel_plot_sink dut (
    .clock_all     (clock_all),
    .reset_all     (reset_all),
    .bus           (bus),
    .sprite_done   (sprite_done),
    .busy          (busy),
    .plotted_count (plotted_count)
  );

  initial clock_all = 1'b0;
  always #5 clock_all = ~clock_all;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected framebuffer writes, in order.
  logic [FB_ADDR_W-1:0] exp_addr_q [$];
  logic [COLOUR_W-1:0]  exp_data_q [$];
  int                   writes;
  int                   extra;
  int                   order_bad;
  int                   dones;
  int                   ready_low;
  logic [FB_ADDR_W-1:0] first_addr;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock_all);
    #1;
  endtask

  task automatic drive(input logic v, input int x, input int y,
                       input int c, input logic last);
    bus.in_valid  = v;
    bus.in_x      = 9'(x);
    bus.in_y      = 8'(y);
    bus.in_colour = 3'(c);
    bus.in_last   = last;
  endtask

  task automatic sb_clear();
    exp_addr_q.delete();
    exp_data_q.delete();
    writes    = 0;
    extra     = 0;
    order_bad = 0;
    dones     = 0;
    ready_low = 0;
    first_addr = '0;
  endtask

  task automatic sb_expect(input int x, input int y, input int c);
    exp_addr_q.push_back(17'(y * 320 + x));
    exp_data_q.push_back(3'(c));
  endtask

  task automatic sb_sample();
    logic [FB_ADDR_W-1:0] ea;
    logic [COLOUR_W-1:0]  ed;
    if (bus.fb_wren === 1'b1) begin
      if (writes == 0) first_addr = bus.fb_addr;
      writes++;
      if (exp_addr_q.size() == 0) begin
        extra++;
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (bus.fb_addr !== ea || bus.fb_data !== ed) order_bad++;
      end
    end
    if (sprite_done === 1'b1) dones++;
  endtask

  task automatic apply_reset();
    reset_all = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
    tick();
    tick();
    reset_all = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    logic rdy;

    // ---------------- reset ----------------
    reset_all = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
    tick();
    tick();
    check("rst in_ready", bus.in_ready, 0);
    check("rst fb_wren", bus.fb_wren, 0);
    check("rst fb_addr", bus.fb_addr, 0);
    check("rst fb_data", bus.fb_data, 0);
    check("rst sprite_done", sprite_done, 0);
    check("rst busy", busy, 0);
    check("rst plotted", plotted_count, 0);
    reset_all = 1'b0;
    tick();
    check("post-rst in_ready", bus.in_ready, 1);

    // ---------------- single pixel ----------------
    drive(1'b1, 10, 5, 3'b101, 1'b1);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    check("single busy in fifo", busy, 1);
    check("single no early write", bus.fb_wren, 0);
    tick();
    check("single fb_wren", bus.fb_wren, 1);
    check("single fb_addr", bus.fb_addr, 1610);
    check("single fb_data", bus.fb_data, 3'b101);
    check("single sprite_done", sprite_done, 1);
    tick();
    check("single wren drop", bus.fb_wren, 0);
    check("single done drop", sprite_done, 0);
    check("single plotted", plotted_count, 1);
    check("single addr hold", bus.fb_addr, 1610);
    check("single idle", busy, 0);

    // ---------------- 62x63 burst at (20,30) ----------------
    sb_clear();
    for (int i = 0; i < 62 * 63; i++) begin
      drive(1'b1, 20 + i % 62, 30 + i / 62, i % 7 + 1, i == 62 * 63 - 1);
      sb_expect(20 + i % 62, 30 + i / 62, i % 7 + 1);
      if (bus.in_ready !== 1'b1) ready_low++;
      tick();
      sb_sample();
    end
    drive(1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      sb_sample();
    end
    check("burst first addr", first_addr, 9620);
    check("burst writes", writes, 3906);
    check("burst order", order_bad, 0);
    check("burst extra", extra, 0);
    check("burst missing", exp_addr_q.size(), 0);
    check("burst ready low", ready_low, 0);
    check("burst sprite_done", dones, 1);
    check("burst plotted", plotted_count, 3907);
    check("burst idle", busy, 0);

    // ---------------- clipping ----------------
    apply_reset();
    drive(1'b1, 319, 239, 3'b010, 1'b0);
    tick();
    drive(1'b1, 320, 0, 3'b011, 1'b0);
    tick();
    check("clip edge wren", bus.fb_wren, 1);
    check("clip edge addr", bus.fb_addr, 76799);
    check("clip edge data", bus.fb_data, 3'b010);
    drive(1'b1, 0, 240, 3'b100, 1'b1);
    tick();
    check("clip x wren", bus.fb_wren, 0);
    check("clip x addr hold", bus.fb_addr, 76799);
    check("clip x done", sprite_done, 0);
    drive(1'b0, 0, 0, 0, 1'b0);
    tick();
    check("clip y wren", bus.fb_wren, 0);
    check("clip y done", sprite_done, 1);
    tick();
    check("clip plotted", plotted_count, 1);
    check("clip idle", busy, 0);

    // ---------------- transparency ----------------
    drive(1'b1, 5, 5, 3'b000, 1'b1);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    tick();
    check("transp wren", bus.fb_wren, 0);
    check("transp done", sprite_done, 1);
    check("transp data hold", bus.fb_data, 3'b010);
    tick();
    check("transp plotted", plotted_count, 1);

    // ---------------- streaming through reset release ----------------
    sb_clear();
    reset_all = 1'b1;
    drive(1'b1, 100, 1, 1, 1'b0);
    tick();
    check("bp in_ready in reset", bus.in_ready, 0);
    reset_all = 1'b0;
    p = 0;
    for (int c = 0; c < 16; c++) begin
      if (p < 8) drive(1'b1, 100 + p, 1, p % 7 + 1, p == 7);
      else       drive(1'b0, 0, 0, 0, 1'b0);
      rdy = bus.in_valid && bus.in_ready;
      tick();
      sb_sample();
      if (rdy) begin
        sb_expect(100 + p, 1, p % 7 + 1);
        p++;
      end
    end
    check("bp accepted", p, 8);
    check("bp writes", writes, 8);
    check("bp order", order_bad, 0);
    check("bp extra", extra, 0);
    check("bp missing", exp_addr_q.size(), 0);
    check("bp sprite_done", dones, 1);
    check("bp plotted", plotted_count, 8);

    // ---------------- reset mid-sprite ----------------
    apply_reset();
    sb_clear();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i, 2, 3'b111, i == 9);
      tick();
    end
    check("mid plotted before", plotted_count, 8);
    check("mid wren before", bus.fb_wren, 1);
    reset_all = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
    tick();
    check("mid rst wren", bus.fb_wren, 0);
    check("mid rst busy", busy, 0);
    check("mid rst plotted", plotted_count, 0);
    check("mid rst ready", bus.in_ready, 0);
    reset_all = 1'b0;
    tick();
    check("mid ready after", bus.in_ready, 1);
    sb_sample();
    tick();
    sb_sample();
    check("mid no writes", writes, 0);
    check("mid no done", dones, 0);
    check("mid idle", busy, 0);
    check("mid plotted after", plotted_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
